// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, condition-code type and branch/move condition evaluation
// for the execute stage.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    // Condition outcome for cmovXX / jXX from the flags in effect before the op.
    function automatic logic cond_eval(cc_t cc, logic [3:0] ifun);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (ifun)
            C_YES:   return 1'b1;
            C_LE:    return lt | cc.zf;
            C_L:     return lt;
            C_E:     return cc.zf;
            C_NE:    return !cc.zf;
            C_GE:    return !lt;
            C_G:     return !lt && !cc.zf;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_iter_mul.sv
// Radix-2 shift-add multiplier returning the low WIDTH bits of a*b; one bit per cycle,
// done asserts WIDTH cycles after start and stays high until the next start.
`ifdef Y86_EXEC_MUL_EN
module y86_iter_mul #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, done_q, done_d;

    // The start cycle already consumes multiplier bit 0, so WIDTH edges cover all bits.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = done_q;
        if (start) begin
            a_d    = a << 1;
            b_d    = b >> 1;
            acc_d  = b[0] ? a : '0;
            cnt_d  = CW'(1);
            run_d  = 1'b1;
            done_d = 1'b0;
        end else if (run_q) begin
            if (b_q[0]) begin
                acc_d = acc_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule
`endif

// File: rtl/y86_exec_stage.sv
// Registered Y86-64 execute stage: valE/Cnd, condition codes, valid/ready on both sides.
// Define Y86_EXEC_MUL_EN to add an iterative mulq (icode 6, ifun 4).
module y86_exec_stage
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned STACK_STEP = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    input  logic             set_cc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] valE,
    output logic             Cnd,
    output logic             out_err,
    output logic [2:0]       cc,
    output logic             busy
);

    logic [WIDTH-1:0] res_c;
    logic             cnd_c, err_c, cc_wr_c, of_c, mul_c;
    logic             a_s, b_s, idle_c, accept_c;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] vale_q, vale_d;
    logic             cnd_q, cnd_d, err_q, err_d;
    cc_t              cc_q, cc_d;

`ifdef Y86_EXEC_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_e;
    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             mul_sc_q, mul_sc_d;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    y86_iter_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_c && mul_c),
        .a       (valA),
        .b       (valB),
        .done    (mul_done),
        .product (mul_product)
    );

    assign idle_c = (state_q == S_IDLE);
    assign busy   = busy_q;
`else
    assign idle_c = 1'b1;
    assign busy   = 1'b0;
`endif

    assign a_s      = valA[WIDTH-1];
    assign b_s      = valB[WIDTH-1];
    assign in_ready = idle_c && (!out_valid_q || out_ready) && !flush;
    assign accept_c = in_valid && in_ready;

    // Single-cycle datapath and legality decode for the op on the inputs.
    always_comb begin
        res_c   = '0;
        cnd_c   = 1'b0;
        err_c   = 1'b0;
        cc_wr_c = 1'b0;
        of_c    = 1'b0;
        mul_c   = 1'b0;
        case (icode)
            I_RRMOVQ, I_JXX: begin
                if (ifun > C_G) begin
                    err_c = 1'b1;
                end else begin
                    res_c = (icode == I_RRMOVQ) ? valA : '0;
                    cnd_c = cond_eval(cc_q, ifun);
                end
            end
            I_IRMOVQ:           res_c = valC;
            I_RMMOVQ, I_MRMOVQ: res_c = valB + valC;
            I_CALL, I_PUSHQ:    res_c = valB - WIDTH'(STACK_STEP);
            I_RET, I_POPQ:      res_c = valB + WIDTH'(STACK_STEP);
            I_OPQ: begin
                cc_wr_c = 1'b1;
                case (ifun)
                    ALU_ADD: begin
                        res_c = valB + valA;
                        of_c  = (a_s == b_s) && (res_c[WIDTH-1] != a_s);
                    end
                    ALU_SUB: begin
                        res_c = valB - valA;
                        of_c  = (b_s != a_s) && (res_c[WIDTH-1] != b_s);
                    end
                    ALU_AND: res_c = valB & valA;
                    ALU_XOR: res_c = valB ^ valA;
`ifdef Y86_EXEC_MUL_EN
                    ALU_MUL: begin
                        cc_wr_c = 1'b0;
                        mul_c   = 1'b1;
                    end
`endif
                    default: begin
                        cc_wr_c = 1'b0;
                        err_c   = 1'b1;
                    end
                endcase
            end
            default: err_c = 1'b1;
        endcase
    end

    // Output register, CC register and multiply sequencing.
    always_comb begin
        out_valid_d = out_valid_q;
        vale_d      = vale_q;
        cnd_d       = cnd_q;
        err_d       = err_q;
        cc_d        = cc_q;
`ifdef Y86_EXEC_MUL_EN
        state_d     = state_q;
        mul_sc_d    = mul_sc_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            out_valid_d = 1'b0;
`ifdef Y86_EXEC_MUL_EN
            state_d     = S_IDLE;
`endif
        end else if (accept_c && !mul_c) begin
            out_valid_d = 1'b1;
            vale_d      = res_c;
            cnd_d       = cnd_c;
            err_d       = err_c;
            if (cc_wr_c && set_cc) begin
                cc_d = '{zf: (res_c == '0), sf: res_c[WIDTH-1], of: of_c};
            end
        end
`ifdef Y86_EXEC_MUL_EN
        else if (accept_c) begin
            state_d  = S_MUL;
            mul_sc_d = set_cc;
        end else if (state_q == S_MUL && mul_done && (!out_valid_q || out_ready)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b1;
            vale_d      = mul_product;
            cnd_d       = 1'b0;
            err_d       = 1'b0;
            if (mul_sc_q) begin
                cc_d = '{zf: (mul_product == '0), sf: mul_product[WIDTH-1], of: 1'b0};
            end
        end
        busy_d = (state_d == S_MUL);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            vale_q      <= '0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            cc_q        <= CC_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            vale_q      <= vale_d;
            cnd_q       <= cnd_d;
            err_q       <= err_d;
            cc_q        <= cc_d;
        end
    end

`ifdef Y86_EXEC_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            mul_sc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            mul_sc_q <= mul_sc_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign valE      = vale_q;
    assign Cnd       = cnd_q;
    assign out_err   = err_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_y86_exec_stage.sv
// Bench for y86_exec_stage: directed vector table, handshake/flush sequences,
// optional mulq sequences, then randomized traffic against a reference model.
module tb_y86_exec_stage;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [3:0]    icode = '0, ifun = '0;
    logic [W-1:0]  valA = '0, valB = '0, valC = '0;
    logic          set_cc = 1'b0, flush = 1'b0;
    logic          out_valid, out_ready = 1'b1;
    logic [W-1:0]  valE;
    logic          Cnd, out_err, busy;
    logic [2:0]    cc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    y86_exec_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .set_cc(set_cc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .valE(valE), .Cnd(Cnd), .out_err(out_err), .cc(cc), .busy(busy)
    );

    typedef struct {
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [63:0] a, b, c;
        logic        sc;
        logic [63:0] ev;
        logic        ecnd;
        logic        eerr;
        logic [2:0]  ecc;
    } vec_t;

    typedef struct {
        logic [63:0] vale;
        logic        cnd;
        logic        err;
        logic [2:0]  cc;
    } res_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic sc);
        icode = ic; ifun = fn; valA = a; valB = b; valC = c; set_cc = sc;
    endtask

    function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] c, input logic sc,
                                input logic [63:0] ev, input logic ecnd, input logic eerr,
                                input logic [2:0] ecc);
        vec_t v;
        v.ic = ic; v.fn = fn; v.a = a; v.b = b; v.c = c; v.sc = sc;
        v.ev = ev; v.ecnd = ecnd; v.eerr = eerr; v.ecc = ecc;
        return v;
    endfunction

    // Architectural model: signed overflow from a 65-bit exact sum, flags {ZF,SF,OF}.
    function automatic res_t ref_model(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] c, input logic sc, input logic [2:0] ccin);
        res_t r;
        logic signed [64:0] wide;
        logic zf, sf, of, ovf, is_alu;
        zf = ccin[2]; sf = ccin[1]; of = ccin[0];
        r.vale = 64'd0; r.cnd = 1'b0; r.err = 1'b0; r.cc = ccin;
        ovf = 1'b0; is_alu = 1'b0;
        if (ic == 4'h2 || ic == 4'h7) begin
            if (fn > 4'd6) r.err = 1'b1;
            else begin
                r.vale = (ic == 4'h2) ? a : 64'd0;
                case (fn)
                    4'd0: r.cnd = 1'b1;
                    4'd1: r.cnd = (sf != of) || zf;
                    4'd2: r.cnd = (sf != of);
                    4'd3: r.cnd = zf;
                    4'd4: r.cnd = !zf;
                    4'd5: r.cnd = (sf == of);
                    default: r.cnd = (sf == of) && !zf;
                endcase
            end
        end else if (ic == 4'h3) r.vale = c;
        else if (ic == 4'h4 || ic == 4'h5) r.vale = b + c;
        else if (ic == 4'h8 || ic == 4'hA) r.vale = b - 64'd8;
        else if (ic == 4'h9 || ic == 4'hB) r.vale = b + 64'd8;
        else if (ic == 4'h6) begin
            is_alu = 1'b1;
            if (fn == 4'd0) begin
                wide = $signed({b[63], b}) + $signed({a[63], a});
                r.vale = wide[63:0]; ovf = (wide[64] != wide[63]);
            end else if (fn == 4'd1) begin
                wide = $signed({b[63], b}) - $signed({a[63], a});
                r.vale = wide[63:0]; ovf = (wide[64] != wide[63]);
            end else if (fn == 4'd2) r.vale = a & b;
            else if (fn == 4'd3) r.vale = a ^ b;
            else begin
                r.err = 1'b1; is_alu = 1'b0;
            end
        end else r.err = 1'b1;
        if (is_alu && sc) r.cc = {r.vale == 64'd0, r.vale[63], ovf};
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] max_pos, min_neg, neg8, ones;
        logic        ov_m, exp_rdy, acc, iv, ordy, fl;
        logic [2:0]  cc_m;
        res_t        exp_m, r;
        int          n;
        logic [3:0]  ric, rfn;
        logic [63:0] ra, rb, rc;

        max_pos = 64'h7FFF_FFFF_FFFF_FFFF;
        min_neg = 64'h8000_0000_0000_0000;
        neg8    = 64'hFFFF_FFFF_FFFF_FFF8;
        ones    = 64'hFFFF_FFFF_FFFF_FFFF;

        vecs.push_back(mk(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b100));
        vecs.push_back(mk(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 3'b100));
        vecs.push_back(mk(4'h6, 4'h0, 64'd1, max_pos, 64'd0, 1'b1, min_neg, 1'b0, 1'b0, 3'b011));
        vecs.push_back(mk(4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 1'b1, 64'h55, 1'b0, 1'b0, 3'b011));
        vecs.push_back(mk(4'h2, 4'h1, 64'h66, 64'd0, 64'd0, 1'b1, 64'h66, 1'b0, 1'b0, 3'b011));
        vecs.push_back(mk(4'h8, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1, 64'hF8, 1'b0, 1'b0, 3'b011));
        vecs.push_back(mk(4'h9, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1, 64'h108, 1'b0, 1'b0, 3'b011));
        vecs.push_back(mk(4'h5, 4'h0, 64'd0, 64'h10, 64'd7, 1'b1, 64'h17, 1'b0, 1'b0, 3'b011));
        vecs.push_back(mk(4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 1'b0, 64'h30, 1'b0, 1'b0, 3'b011));
        vecs.push_back(mk(4'hE, 4'h0, 64'd1, 64'd2, 64'd3, 1'b1, 64'd0, 1'b0, 1'b1, 3'b011));
        vecs.push_back(mk(4'h6, 4'h1, 64'd1, min_neg, 64'd0, 1'b1, max_pos, 1'b0, 1'b0, 3'b001));
        vecs.push_back(mk(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b001));
        vecs.push_back(mk(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 3'b001));
        vecs.push_back(mk(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b001));
        vecs.push_back(mk(4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 3'b001));
        vecs.push_back(mk(4'h2, 4'h7, 64'h9, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 3'b001));
        vecs.push_back(mk(4'h6, 4'h5, 64'd3, 64'd3, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 3'b001));
`ifndef Y86_EXEC_MUL_EN
        vecs.push_back(mk(4'h6, 4'h4, 64'd3, 64'd3, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 3'b001));
`endif
        vecs.push_back(mk(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD, 1'b1, 64'hDEAD, 1'b0, 1'b0, 3'b001));
        vecs.push_back(mk(4'h4, 4'h0, 64'd0, 64'h1000, neg8, 1'b1, 64'hFF8, 1'b0, 1'b0, 3'b001));
        vecs.push_back(mk(4'hA, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1, neg8, 1'b0, 1'b0, 3'b001));
        vecs.push_back(mk(4'hB, 4'h0, 64'd0, neg8, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b001));
        vecs.push_back(mk(4'h6, 4'h3, 64'h1234, 64'h1234, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b100));
        vecs.push_back(mk(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b100));
        vecs.push_back(mk(4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 3'b100));
        vecs.push_back(mk(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 3'b100));
        vecs.push_back(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 3'b100));
        vecs.push_back(mk(4'h6, 4'h0, ones, 64'd1, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 3'b100));

        // Reset state
        #12;
        check("reset out_valid", out_valid, 0);
        check("reset valE", valE, 0);
        check("reset Cnd", Cnd, 0);
        check("reset out_err", out_err, 0);
        check("reset cc", cc, 3'b100);
        check("reset busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ic, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sc);
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d valE", i), valE, vecs[i].ev);
            check($sformatf("vec%0d Cnd", i), Cnd, vecs[i].ecnd);
            check($sformatf("vec%0d out_err", i), out_err, vecs[i].eerr);
            check($sformatf("vec%0d cc", i), cc, vecs[i].ecc);
        end

        // Stall with a second op waiting, then release
        @(negedge clk); drive(4'h3, 4'h0, 0, 0, 64'hA1, 0); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall first valE", valE, 64'hA1);
        @(negedge clk); drive(4'h3, 4'h0, 0, 0, 64'hB2, 0); out_ready = 1'b0; #1;
        check("stall in_ready low", in_ready, 0);
        @(posedge clk); #1;
        check("stall held valE", valE, 64'hA1);
        check("stall held out_valid", out_valid, 1);
        @(negedge clk); #1;
        check("stall in_ready still low", in_ready, 0);
        @(posedge clk); #1;
        check("stall held valE 2", valE, 64'hA1);
        @(negedge clk); out_ready = 1'b1; #1;
        check("release in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("second delivered valid", out_valid, 1);
        check("second delivered valE", valE, 64'hB2);
        @(posedge clk); #1;
        check("drained out_valid", out_valid, 0);

        // Flush while stalled; a same-cycle op must not be accepted
        @(negedge clk); drive(4'h3, 4'h0, 0, 0, 64'hC3, 0); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); drive(4'h6, 4'h0, 64'd1, max_pos, 0, 1); out_ready = 1'b0; flush = 1'b1; #1;
        check("flush blocks in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("flush out_valid", out_valid, 0);
        check("flush cc untouched", cc, 3'b100);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

`ifdef Y86_EXEC_MUL_EN
        // mulq: 6 * -7
        @(negedge clk); drive(4'h6, 4'h4, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 0, 1); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mul busy", busy, 1);
        check("mul in_ready low", in_ready, 0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("mul latency", 64'(n), 64'(W));
        check("mul valE", valE, 64'hFFFF_FFFF_FFFF_FFD6);
        check("mul cc", cc, 3'b010);
        check("mul busy done", busy, 0);
        // flush mid-multiply
        @(negedge clk); drive(4'h6, 4'h4, 64'd3, 64'd3, 0, 1); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("mul flush busy", busy, 0);
        check("mul flush out_valid", out_valid, 0);
        repeat (W + 4) @(posedge clk);
        #1;
        check("mul flush no output", out_valid, 0);
        check("mul flush cc", cc, 3'b010);
        // asynchronous reset mid-multiply
        @(negedge clk); drive(4'h6, 4'h4, 64'd5, 64'd5, 0, 1); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0; #1;
        check("async reset busy", busy, 0);
        check("async reset cc", cc, 3'b100);
        @(negedge clk); rst_n = 1'b1;
`endif

        // Asynchronous reset with a pending result and modified flags
        @(negedge clk); drive(4'h6, 4'h0, 64'd1, max_pos, 0, 1); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre-reset cc", cc, 3'b011);
        #2 rst_n = 1'b0; #1;
        check("async reset out_valid", out_valid, 0);
        check("async reset valE", valE, 0);
        check("async reset flags", cc, 3'b100);
        @(negedge clk); rst_n = 1'b1;

        // Randomized traffic against the reference model
        ov_m = 1'b0; cc_m = 3'b100;
        exp_m.vale = '0; exp_m.cnd = 1'b0; exp_m.err = 1'b0; exp_m.cc = 3'b100;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            ric  = 4'($urandom_range(0, 15));
            rfn  = 4'($urandom_range(0, 7));
`ifdef Y86_EXEC_MUL_EN
            if (ric == 4'h6 && rfn == 4'h4) rfn = 4'h5;
`endif
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            rc = {$urandom, $urandom};
            drive(ric, rfn, ra, rb, rc, 1'($urandom_range(0, 1)));
            in_valid = iv; out_ready = ordy; flush = fl;
            #1;
            exp_rdy = (!ov_m || ordy) && !fl;
            check($sformatf("rnd%0d in_ready", k), in_ready, exp_rdy);
            acc = iv && exp_rdy;
            r = ref_model(ric, rfn, ra, rb, rc, set_cc, cc_m);
            @(posedge clk); #1;
            if (fl) ov_m = 1'b0;
            else if (acc) begin
                ov_m = 1'b1; exp_m = r; cc_m = r.cc;
            end else if (ordy) ov_m = 1'b0;
            check($sformatf("rnd%0d out_valid", k), out_valid, ov_m);
            if (ov_m) begin
                check($sformatf("rnd%0d valE", k), valE, exp_m.vale);
                check($sformatf("rnd%0d Cnd", k), Cnd, exp_m.cnd);
                check($sformatf("rnd%0d out_err", k), out_err, exp_m.err);
            end
            check($sformatf("rnd%0d cc", k), cc, cc_m);
            check($sformatf("rnd%0d busy", k), busy, 0);
        end
        @(negedge clk); in_valid = 1'b0; flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
